// File: rtl/drp_adc_responder.sv
// DRP-compatible stand-in for the XADC joystick path: a fixed-latency DRP
// responder plus a two-channel (aux6/aux7) conversion sequencer.
module drp_adc_responder #(
  parameter int RD_LATENCY  = 4,
  parameter int CONV_CYCLES = 26,
  parameter int GAP_CYCLES  = 1
) (
  input  logic        clk_100MHz,
  input  logic        rst_n,
  input  logic [6:0]  daddr_in,
  input  logic        den_in,
  input  logic        dwe_in,
  input  logic [15:0] di_in,
  output logic [15:0] do_out,
  output logic        drdy_out,
  input  logic [11:0] aux6_sample,
  input  logic [11:0] aux7_sample,
  output logic        busy_out,
  output logic        eoc_out,
  output logic [6:0]  channel_out,
  output logic        protocol_err,
  output logic        drp_state_dbg,
  output logic [1:0]  seq_state_dbg
);
  // DRP handshake: den_in is a one-cycle request strobe accepted only in D_IDLE;
  // drdy_out is a one-cycle pulse exactly RD_LATENCY cycles after acceptance,
  // with do_out valid in that cycle and held afterwards.
  typedef enum logic {D_IDLE, D_WAIT} drp_state_t;
  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE, S_GAP} seq_state_t;

  localparam logic [6:0] ADDR_RES6 = 7'h16;
  localparam logic [6:0] ADDR_RES7 = 7'h17;
  localparam logic [6:0] ADDR_CFG0 = 7'h40;
  localparam logic [6:0] ADDR_CFG1 = 7'h41;

  drp_state_t  drp_state_q, drp_state_d;
  logic [3:0]  lat_cnt_q, lat_cnt_d;
  logic [6:0]  addr_q, addr_d;
  logic        we_q, we_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] snap_q, snap_d;
  logic [15:0] do_hold_q, do_hold_d;
  logic        perr_q, perr_d;
  logic [15:0] cfg0_q, cfg0_d;
  logic [15:0] cfg1_q, cfg1_d;
  logic [11:0] res6_q, res6_d;
  logic [11:0] res7_q, res7_d;

  seq_state_t  seq_state_q, seq_state_d;
  logic [7:0]  seq_cnt_q, seq_cnt_d;
  logic        next_ch_q, next_ch_d;
  logic [6:0]  chan_q, chan_d;
  logic [11:0] samp_q, samp_d;
  logic        start_conv;
  logic [15:0] rd_data;

  // Results keep only the 12 sample bits; the low nibble always reads as zero.
  always_comb begin
    rd_data = 16'h0000;
    case (daddr_in)
      ADDR_RES6: rd_data = {res6_q, 4'h0};
      ADDR_RES7: rd_data = {res7_q, 4'h0};
      ADDR_CFG0: rd_data = cfg0_q;
      ADDR_CFG1: rd_data = cfg1_q;
      default:   rd_data = 16'h0000;
    endcase
  end

  always_comb begin
    drp_state_d = drp_state_q;
    lat_cnt_d   = lat_cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    snap_d      = snap_q;
    do_hold_d   = do_hold_q;
    perr_d      = perr_q;
    cfg0_d      = cfg0_q;
    cfg1_d      = cfg1_q;
    drdy_out    = 1'b0;
    do_out      = do_hold_q;
    case (drp_state_q)
      D_IDLE: begin
        if (den_in) begin
          addr_d      = daddr_in;
          we_d        = dwe_in;
          wdata_d     = di_in;
          snap_d      = rd_data;
          lat_cnt_d   = 4'(RD_LATENCY);
          drp_state_d = D_WAIT;
        end
      end
      default: begin
        if (den_in) perr_d = 1'b1;
        if (lat_cnt_q == 4'd1) begin
          drdy_out    = 1'b1;
          do_out      = we_q ? 16'h0000 : snap_q;
          do_hold_d   = do_out;
          drp_state_d = D_IDLE;
          if (we_q && addr_q == ADDR_CFG0) cfg0_d = wdata_q;
          if (we_q && addr_q == ADDR_CFG1) cfg1_d = wdata_q;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
    endcase
  end

  always_comb begin
    seq_state_d = seq_state_q;
    seq_cnt_d   = seq_cnt_q;
    next_ch_d   = next_ch_q;
    chan_d      = chan_q;
    samp_d      = samp_q;
    res6_d      = res6_q;
    res7_d      = res7_q;
    start_conv  = 1'b0;
    busy_out    = (seq_state_q == S_CONV);
    eoc_out     = (seq_state_q == S_DONE);
    case (seq_state_q)
      S_IDLE: start_conv = cfg1_q[0];
      S_CONV: begin
        if (seq_cnt_q == 8'd0) seq_state_d = S_DONE;
        else                   seq_cnt_d   = seq_cnt_q - 8'd1;
      end
      S_DONE: begin
        if (chan_q == ADDR_RES6) res6_d = samp_q;
        else                     res7_d = samp_q;
        if (GAP_CYCLES == 0) begin
          start_conv  = cfg1_q[0];
          seq_state_d = S_IDLE;
        end else begin
          seq_cnt_d   = 8'(GAP_CYCLES - 1);
          seq_state_d = S_GAP;
        end
      end
      default: begin
        if (seq_cnt_q == 8'd0) begin
          start_conv  = cfg1_q[0];
          seq_state_d = S_IDLE;
        end else begin
          seq_cnt_d = seq_cnt_q - 8'd1;
        end
      end
    endcase
    // Sample is frozen at CONV entry so input movement mid-conversion is ignored.
    if (start_conv) begin
      seq_state_d = S_CONV;
      seq_cnt_d   = 8'(CONV_CYCLES - 1);
      samp_d      = next_ch_q ? aux7_sample : aux6_sample;
      chan_d      = next_ch_q ? ADDR_RES7 : ADDR_RES6;
      next_ch_d   = ~next_ch_q;
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (!rst_n) begin
      drp_state_q <= D_IDLE;
      lat_cnt_q   <= 4'd0;
      addr_q      <= 7'd0;
      we_q        <= 1'b0;
      wdata_q     <= 16'h0000;
      snap_q      <= 16'h0000;
      do_hold_q   <= 16'h0000;
      perr_q      <= 1'b0;
      cfg0_q      <= 16'h0000;
      cfg1_q      <= 16'h0001;
      res6_q      <= 12'h000;
      res7_q      <= 12'h000;
      seq_state_q <= S_IDLE;
      seq_cnt_q   <= 8'd0;
      next_ch_q   <= 1'b0;
      chan_q      <= 7'd0;
      samp_q      <= 12'h000;
    end else begin
      drp_state_q <= drp_state_d;
      lat_cnt_q   <= lat_cnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      snap_q      <= snap_d;
      do_hold_q   <= do_hold_d;
      perr_q      <= perr_d;
      cfg0_q      <= cfg0_d;
      cfg1_q      <= cfg1_d;
      res6_q      <= res6_d;
      res7_q      <= res7_d;
      seq_state_q <= seq_state_d;
      seq_cnt_q   <= seq_cnt_d;
      next_ch_q   <= next_ch_d;
      chan_q      <= chan_d;
      samp_q      <= samp_d;
    end
  end

  assign channel_out   = chan_q;
  assign protocol_err  = perr_q;
  assign drp_state_dbg = drp_state_q;
  assign seq_state_dbg = seq_state_q;
endmodule

// File: doc/drp_adc_responder.md
Name: drp_adc_responder

Overview:
- DRP-compatible responder that emulates the XADC dynamic reconfiguration port for the joystick path.
- It runs its own conversion sequencer over aux channels 6 and 7, fed from digital sample inputs.
- It answers DRP reads and writes with a fixed, parameterised latency.
- Uses: drop-in replacement for the hard XADC in simulation, and front-end for boards that use an external ADC behind the same DRP reader.

Parameters:
RD_LATENCY, 4, cycles from den_in acceptance to drdy_out pulse; legal 1..15
CONV_CYCLES, 26, busy_out duration per conversion; legal 2..255
GAP_CYCLES, 1, idle cycles between conversions; legal 0..15

Ports:
clk_100MHz  in  1  sole clock
rst_n  in  1  synchronous active-low reset
daddr_in  in  7  DRP register address
den_in  in  1  DRP enable, single-cycle request strobe
dwe_in  in  1  DRP write enable, qualified by den_in
di_in  in  16  DRP write data
do_out  out  16  DRP read data
drdy_out  out  1  DRP ready, one-cycle pulse
aux6_sample  in  12  current digital value for channel 6 (X axis)
aux7_sample  in  12  current digital value for channel 7 (Y axis)
busy_out  out  1  conversion in progress
eoc_out  out  1  end-of-conversion pulse
channel_out  out  7  address of channel being / last converted
protocol_err  out  1  sticky: den_in received while a transaction was pending

Behaviour:
- Reset, applied at a clk_100MHz edge with rst_n=0: every output is 0; the result registers are 0x0000; CFG0 is 0x0000; CFG1 is 0x0001; the sequencer is in IDLE; any pending DRP transaction is dropped and produces no drdy_out.
- Register map, addressed by daddr_in:
  - 0x16: RES6, read-only, holds {aux6 sample, 4'b0}.
  - 0x17: RES7, read-only, holds {aux7 sample, 4'b0}.
  - 0x40: CFG0, read/write, free scratch register.
  - 0x41: CFG1, read/write; bit0 is SEQ_EN.
  - Any other address reads 0x0000. Writes to read-only or unmapped addresses are ignored but still acknowledged.
- DRP handshake FSM with states D_IDLE and D_WAIT:
  - D_IDLE with den_in=1: capture daddr/dwe/di; snapshot the read data for the captured address; load the latency counter with RD_LATENCY; go to D_WAIT.
  - D_WAIT: decrement the counter. When the counter expires, drdy_out=1 for exactly one cycle, do_out is driven with the snapshot (reads) or 0x0000 (writes), and the FSM returns to D_IDLE.
  - den_in=1 in the same cycle that drdy_out is high counts as pending, so it is ignored.
  - Latency is exact: den_in at cycle N gives drdy_out at cycle N+RD_LATENCY.
  - Writes take effect in the drdy_out cycle.
  - do_out holds its last value between transactions.
  - den_in during D_WAIT: ignored, protocol_err set to 1 and held until reset; the in-flight transaction completes unaffected.
- Sequencer FSM with states IDLE, CONV, DONE and GAP:
  - IDLE → CONV when SEQ_EN=1. The first channel after reset is 0x16; afterwards channels alternate 0x16, 0x17, 0x16, ...
  - CONV: busy_out=1 and channel_out = current channel. The sample input is latched at CONV entry. The state lasts exactly CONV_CYCLES cycles.
  - DONE, one cycle: busy_out=0; the result register is written with {latched sample, 4'b0000}; eoc_out=1; channel_out is unchanged. Then go to GAP, or straight to the next CONV if GAP_CYCLES=0 and SEQ_EN=1.
  - GAP lasts GAP_CYCLES cycles. At its end: go to CONV if SEQ_EN=1, otherwise IDLE.
  - Clearing SEQ_EN mid-CONV: the current conversion completes (DONE/eoc) and the sequencer then returns to IDLE.
  - Re-enabling resumes with the channel after the last one converted.
- Simultaneous events:
  - DRP read acceptance in the same cycle as DONE updating the same register returns the old value.
  - A DRP write to CFG1 takes effect at drdy_out; the sequencer samples SEQ_EN from the following cycle.
  - A sample input changing during CONV does not affect the result.
- Width rules:
  - Result bits [3:0] are always 0.
  - Unused DRP address bits are fully decoded, so 0x96 is not an alias of 0x16 (only 7 bits exist anyway).

Test Plan:
1. Reset then idle 200 cycles with aux6_sample=0x800 and aux7_sample=0x3FF → first eoc_out at cycle CONV_CYCLES+1 after reset release with channel_out=0x16. Reading 0x16 returns 0x8000, reading 0x17 returns 0x3FF0; drdy_out arrives exactly 4 cycles after den_in each time.
2. Write 0x0000 to 0x41 during a conversion → that conversion's eoc_out still fires, no further busy_out occurs; reading 0x41 returns 0x0000. Writing 0x0001 resumes with the alternate channel.
3. den_in issued on cycle N and again at N+2 → one drdy_out at N+4, protocol_err=1 and sticky; the second request gets no response.
4. Read 0x16 accepted on the DONE cycle that updates RES6 from 0x8000 to 0xFFF0 → do_out=0x8000. The next read returns 0xFFF0.
5. Write 0xBEEF to 0x40, read it back → 0xBEEF. Write to 0x16 → drdy_out pulses, RES6 unchanged. Read 0x55 → 0x0000.
6. Assert rst_n=0 for one cycle while in D_WAIT and mid-CONV → no drdy_out, all outputs 0, RES6/RES7 read 0x0000, sequencer restarts on channel 0x16.
